// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined add/subtract unit. The operands are split into CHUNK-bit slices and
// one slice is added per pipeline stage; the slice carry is registered between
// stages. Upper, not-yet-added operand slices travel down the pipe with the
// operation, and finished lower result slices are registered, so the result
// word leaves the last stage fully aligned. One operation per cycle is accepted.
// The whole pipe, bubbles included, advances only when the output slot is free
// or being consumed (adv = !out_valid || out_ready).
//
// Latency: an operation accepted on edge n shows out_valid=1 after edge
// n+STAGES, where STAGES = WIDTH/CHUNK (input register + STAGES adder stages).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   a, b, Ci, sub carry an operation
//   in_ready   unit accepts an operation this cycle (combinational)
//   a, b       operands, WIDTH bits
//   Ci         carry-in, ignored when sub=1
//   sub        0: S = a + b + Ci   1: S = a - b
//   out_valid  S, Co, ovf hold a valid result
//   out_ready  downstream takes the result this cycle
//   S          sum/difference modulo 2^WIDTH
//   Co         carry out of the MSB (for sub: 1 = no borrow)
//   ovf        two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   logic             adv;

   // Level 0 is the input register; level k+1 holds the state after stage k.
   logic [STAGES:0]  vld_q;
   // Carry into stage k; c_q[STAGES] is the final carry-out.
   logic [STAGES:0]  c_q;
   // Operands (b already conditionally inverted) presented to stage k.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   // Result word after stage k: slices 0..k are final.
   logic [WIDTH-1:0] s_q [STAGES];
   logic             ovf_q;

   logic [CHUNK-1:0] slice_sum [STAGES];
   logic [STAGES-1:0] slice_co;
   logic [WIDTH-1:0] s_nxt [STAGES];
   logic             ovf_nxt;

   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[STAGES];
   assign S         = s_q[STAGES-1];
   assign Co        = c_q[STAGES];
   assign ovf       = ovf_q;

   always_comb begin
      // NOTE: every combinational output is fully assigned before it is
      // selectively overwritten, so no path leaves a value held (no latch).
      s_nxt[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         s_nxt[k] = s_q[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         {slice_co[k], slice_sum[k]} = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                                     + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                                     + {{CHUNK{1'b0}}, c_q[k]};
         s_nxt[k][k*CHUNK +: CHUNK] = slice_sum[k];
      end

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
      ovf_nxt = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
              ^ slice_sum[STAGES-1][CHUNK-1] ^ slice_co[STAGES-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the datapath registers are reset too, not just the valid
         // bits: bubbles shift into S, so an unreset datapath would expose X.
         vld_q <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv) begin
         // NOTE: non-blocking assignments let every stage read the previous
         // cycle's value of its neighbour, independent of statement order.
         vld_q            <= {vld_q[STAGES-1:0], in_valid};
         a_q[0]           <= a;
         b_q[0]           <= sub ? ~b : b;
         c_q[0]           <= sub | Ci;
         c_q[STAGES:1]    <= slice_co;
         for (int k = 1; k < STAGES; k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= s_nxt[k];
         end
         ovf_q            <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Scoreboard bench for pipelined_adder (WIDTH=16, CHUNK=4). The driver pushes
// the expected result of every accepted operation into a queue; an independent
// monitor pops and compares whenever the DUT hands over a result.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int LAT   = WIDTH / CHUNK;
   localparam int UMAX  = (1 << WIDTH) - 1;
   localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
   localparam int SMIN  = -(1 << (WIDTH - 1));

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             co;
      logic             ovf;
      int               cyc;
      bit               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             Ci = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] S;
   logic             Co;
   logic             ovf;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb_q[$];
   bit   drv_done;

   pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .Ci        (Ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Co        (Co),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed readings.
   function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                  input logic ici, input logic isub, input bit lat);
      exp_t m;
      int   ua = int'(ia);
      int   ub = int'(ib);
      int   sa = $signed(ia);
      int   sb = $signed(ib);
      int   r;
      int   rs;
      if (isub) begin
         r    = ua - ub;
         rs   = sa - sb;
         m.co = (ua >= ub);
      end else begin
         r    = ua + ub + int'(ici);
         rs   = sa + sb + int'(ici);
         m.co = (r > UMAX);
      end
      m.s   = r[WIDTH-1:0];
      m.ovf = (rs > SMAX) || (rs < SMIN);
      m.cyc = 0;
      m.lat = lat;
      return m;
   endfunction

   function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic co, input logic o);
      exp_t m;
      m.s   = s;
      m.co  = co;
      m.ovf = o;
      m.cyc = 0;
      m.lat = 1'b1;
      return m;
   endfunction

   // Called aligned to posedge+1; returns aligned to posedge+1 after the accept edge.
   task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ici, input logic isub, input exp_t e);
      int n = 0;
      a        = ia;
      b        = ib;
      Ci       = ici;
      sub      = isub;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready wait", 32'(in_ready), 1);
      e.cyc = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic issue_rand(input bit lat);
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      logic             rsub;
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rc   = 1'($urandom);
      rsub = 1'($urandom);
      issue(ra, rb, rc, rsub, model(ra, rb, rc, rsub, lat));
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 32'(sb_q.size()), 0);
   endtask

   // Monitor: a result is consumed on the edge following a negedge where
   // out_valid && out_ready.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            check("output expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("S", 32'(S), 32'(e.s));
               check("Co", 32'(Co), 32'(e.co));
               check("ovf", 32'(ovf), 32'(e.ovf));
               if (e.lat) check("latency", cyc - e.cyc, LAT);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int   seen;
      logic [WIDTH-1:0] held;

      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 0);
      check("reset S", 32'(S), 0);
      check("reset Co", 32'(Co), 0);
      check("reset ovf", 32'(ovf), 0);
      check("reset in_ready", 32'(in_ready), 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed corner cases, one at a time, each with latency check.
      issue(16'h000A, 16'h0006, 1'b0, 1'b0, mk(16'h0010, 1'b0, 1'b0)); drain();
      issue(16'h000A, 16'h0006, 1'b1, 1'b0, mk(16'h0011, 1'b0, 1'b0)); drain();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0)); drain();
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1)); drain();
      issue(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0)); drain();
      issue(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1)); drain();

      // Back-to-back stream, no stalls: every result at exactly LAT cycles.
      for (int i = 0; i < 8; i++) issue_rand(1'b1);
      drain();

      // Same kind of stream with a 3-cycle stall once results are flowing.
      fork
         begin
            for (int i = 0; i < 8; i++) issue_rand(1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            held      = S;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("stall in_ready", 32'(in_ready), 0);
               @(posedge clk);
               #1;
               check("stall out_valid", 32'(out_valid), 1);
               check("stall S hold", 32'(S), 32'(held));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Random back-pressure and random input gaps.
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               issue_rand(1'b0);
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with one result at the output and three operations in flight.
      for (int i = 0; i < 4; i++) issue_rand(1'b0);
      @(posedge clk);
      #1;
      check("valid before reset", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst S", 32'(S), 0);
      check("rst Co", 32'(Co), 0);
      check("rst ovf", 32'(ovf), 0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("stale after reset", seen, 0);
      @(posedge clk);
      #1;
      issue(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
